// File: rtl/obi_sram_responder.sv
// OBI responder backed by a word-addressed SRAM model with a fixed response latency.
// Define OBI_RESP_ERR_EN to add resp_err_o, which flags responses to out-of-range accesses.
module obi_sram_responder #(
  parameter int unsigned NUM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0,
  parameter int unsigned RESP_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // {req, we, be[3:0], addr[31:0], wdata[31:0]}
  input  logic [69:0] req_i,
  // {gnt, rvalid, rdata[31:0]}
  output logic [33:0] resp_o
`ifdef OBI_RESP_ERR_EN
  ,
  output logic        resp_err_o
`endif
);

  localparam int unsigned AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  logic          req;
  logic          we;
  logic [3:0]    be;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic [31:0]   off;
  logic          in_range;
  logic [AW-1:0] index;
  logic          gnt;
  logic          accept;
  logic          rvalid;
  logic [31:0]   rd_word;
  logic [CW-1:0] count;
  logic          unused_off;

  logic [31:0]             mem        [NUM_WORDS];
  logic [RESP_LATENCY-1:0] pipe_valid;
  logic [31:0]             pipe_data  [RESP_LATENCY];

  assign {req, we, be, addr, wdata} = req_i;

  // Addresses below BASE_ADDR wrap to a huge offset, so the explicit >= test is required.
  assign off        = addr - BASE_ADDR;
  assign in_range   = (addr >= BASE_ADDR) && ({2'b00, off[31:2]} < NUM_WORDS);
  assign index      = off[AW+1:2];
  assign unused_off = ^off[1:0];

  assign gnt    = rst_ni && (count < CW'(MAX_OUTSTANDING));
  assign accept = req && gnt;
  assign rvalid = pipe_valid[RESP_LATENCY-1];

  assign rd_word = (accept && !we && in_range) ? mem[index] : 32'h0;

  assign resp_o = {gnt, rvalid, pipe_data[RESP_LATENCY-1]};

  // Memory contents survive reset; only accepted in-range writes touch it.
  always_ff @(posedge clk_i) begin
    if (accept && we && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[index][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (accept && !rvalid) begin
      count <= count + CW'(1);
    end else if (!accept && rvalid) begin
      count <= count - CW'(1);
    end
  end

  // Stage 0 is loaded on every edge, so idle cycles push zero data and clear valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_valid <= '0;
      for (int i = 0; i < RESP_LATENCY; i++) begin
        pipe_data[i] <= 32'h0;
      end
    end else begin
      pipe_valid[0] <= accept;
      pipe_data[0]  <= rd_word;
      for (int i = 1; i < RESP_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

`ifdef OBI_RESP_ERR_EN
  logic [RESP_LATENCY-1:0] pipe_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_err <= '0;
    end else begin
      pipe_err[0] <= accept && !in_range;
      for (int i = 1; i < RESP_LATENCY; i++) begin
        pipe_err[i] <= pipe_err[i-1];
      end
    end
  end

  assign resp_err_o = pipe_err[RESP_LATENCY-1];
`endif

endmodule

// File: tb/tb_obi_sram_responder.sv
// Directed bench for obi_sram_responder using three latency/outstanding configurations.
// Build with +define+OBI_RESP_ERR_EN to also check resp_err_o.
module tb_obi_sram_responder;

  logic        clk;
  logic        rst_n;
  logic [69:0] req1, req3, req4;
  logic [33:0] resp1, resp3, resp4;
  logic        gnt1, gnt3, gnt4;
  logic        rv1, rv3, rv4;
  logic [31:0] rd1, rd3, rd4;
  int          errors = 0;
  int          checks = 0;

`ifdef OBI_RESP_ERR_EN
  logic err1, err3, err4;
`endif

  assign {gnt1, rv1, rd1} = resp1;
  assign {gnt3, rv3, rd3} = resp3;
  assign {gnt4, rv4, rd4} = resp4;

  obi_sram_responder #(
    .NUM_WORDS(1024), .BASE_ADDR(32'h0000_1000), .RESP_LATENCY(1), .MAX_OUTSTANDING(2)
  ) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req1), .resp_o(resp1)
`ifdef OBI_RESP_ERR_EN
    , .resp_err_o(err1)
`endif
  );

  obi_sram_responder #(
    .NUM_WORDS(64), .BASE_ADDR(32'h0), .RESP_LATENCY(3), .MAX_OUTSTANDING(2)
  ) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req3), .resp_o(resp3)
`ifdef OBI_RESP_ERR_EN
    , .resp_err_o(err3)
`endif
  );

  obi_sram_responder #(
    .NUM_WORDS(64), .BASE_ADDR(32'h0), .RESP_LATENCY(4), .MAX_OUTSTANDING(5)
  ) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req4), .resp_o(resp4)
`ifdef OBI_RESP_ERR_EN
    , .resp_err_o(err4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [69:0] pack(input logic r, input logic w, input logic [3:0] b,
                                       input logic [31:0] a, input logic [31:0] d);
    return {r, w, b, a, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req1  = '0;
    req3  = '0;
    req4  = '0;
    repeat (2) step();
    checks++;
    if (gnt1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_gnt: got %b want 0", gnt1); end
    checks++;
    if (rv1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid: got %b want 0", rv1); end
    checks++;
    if (rd1 !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h want 0", rd1); end
    checks++;
    if (gnt3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_gnt3: got %b want 0", gnt3); end
    rst_n = 1'b1;
    step();
    checks++;
    if (gnt1 !== 1'b1) begin errors++; $display("[TB] FAIL release_gnt: got %b want 1", gnt1); end
    checks++;
    if (gnt4 !== 1'b1) begin errors++; $display("[TB] FAIL release_gnt4: got %b want 1", gnt4); end
    checks++;
    if (rv1 !== 1'b0) begin errors++; $display("[TB] FAIL release_rvalid: got %b want 0", rv1); end
  endtask

  task automatic test_write_read();
    logic [31:0] exp_data [4];
    logic [3:0]  exp_valid;
    exp_data  = '{32'h0, 32'hA5A5_1234, 32'h0, 32'h0};
    exp_valid = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       req1 = pack(1'b1, 1'b1, 4'hF, 32'h0000_1010, 32'hA5A5_1234);
        1:       req1 = pack(1'b1, 1'b0, 4'hF, 32'h0000_1010, 32'h0);
        default: req1 = '0;
      endcase
      #1;
      checks++;
      if (gnt1 !== 1'b1) begin errors++; $display("[TB] FAIL wr_rd_gnt[%0d]: got %b want 1", i, gnt1); end
      step();
      checks++;
      if (rv1 !== exp_valid[i]) begin
        errors++; $display("[TB] FAIL wr_rd_rvalid[%0d]: got %b want %b", i, rv1, exp_valid[i]);
      end
      checks++;
      if (rd1 !== exp_data[i]) begin
        errors++; $display("[TB] FAIL wr_rd_rdata[%0d]: got %h want %h", i, rd1, exp_data[i]);
      end
    end
  endtask

  task automatic test_partial_write();
    logic [31:0] exp_data [7];
    logic [6:0]  exp_valid;
    exp_data  = '{32'h0, 32'h0, 32'h1122_BB44, 32'h0, 32'h1122_BB44, 32'h0, 32'h0};
    exp_valid = 7'b001_1111;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0:       req1 = pack(1'b1, 1'b1, 4'hF,    32'h0000_1014, 32'h1122_3344);
        1:       req1 = pack(1'b1, 1'b1, 4'b0010, 32'h0000_1014, 32'h0000_BB00);
        2:       req1 = pack(1'b1, 1'b0, 4'hF,    32'h0000_1014, 32'h0);
        3:       req1 = pack(1'b1, 1'b1, 4'b0000, 32'h0000_1014, 32'hFFFF_FFFF);
        4:       req1 = pack(1'b1, 1'b0, 4'hF,    32'h0000_1014, 32'h0);
        default: req1 = '0;
      endcase
      step();
      checks++;
      if (rv1 !== exp_valid[i]) begin
        errors++; $display("[TB] FAIL partial_rvalid[%0d]: got %b want %b", i, rv1, exp_valid[i]);
      end
      checks++;
      if (rd1 !== exp_data[i]) begin
        errors++; $display("[TB] FAIL partial_rdata[%0d]: got %h want %h", i, rd1, exp_data[i]);
      end
    end
  endtask

  // 0x0FFC and 0x2010 alias words 1023 and 4 if the decode ignored the range check.
  task automatic test_out_of_range();
    logic [31:0] exp_data [7];
    logic [6:0]  exp_valid;
    logic [6:0]  exp_err;
    exp_data  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h55AA_55AA, 32'hA5A5_1234, 32'h0};
    exp_valid = 7'b011_1111;
    exp_err   = 7'b000_1110;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0:       req1 = pack(1'b1, 1'b1, 4'hF, 32'h0000_1FFC, 32'h55AA_55AA);
        1:       req1 = pack(1'b1, 1'b1, 4'hF, 32'h0000_0FFC, 32'h0);
        2:       req1 = pack(1'b1, 1'b1, 4'hF, 32'h0000_2010, 32'hDEAD_BEEF);
        3:       req1 = pack(1'b1, 1'b0, 4'hF, 32'h0000_2000, 32'h0);
        4:       req1 = pack(1'b1, 1'b0, 4'hF, 32'h0000_1FFC, 32'h0);
        5:       req1 = pack(1'b1, 1'b0, 4'hF, 32'h0000_1010, 32'h0);
        default: req1 = '0;
      endcase
      step();
      checks++;
      if (rv1 !== exp_valid[i]) begin
        errors++; $display("[TB] FAIL oor_rvalid[%0d]: got %b want %b", i, rv1, exp_valid[i]);
      end
      checks++;
      if (rd1 !== exp_data[i]) begin
        errors++; $display("[TB] FAIL oor_rdata[%0d]: got %h want %h", i, rd1, exp_data[i]);
      end
`ifdef OBI_RESP_ERR_EN
      checks++;
      if (err1 !== exp_err[i]) begin
        errors++; $display("[TB] FAIL oor_err[%0d]: got %b want %b", i, err1, exp_err[i]);
      end
`else
      if (exp_err[i] && !rv1) begin
        errors++; $display("[TB] FAIL oor_resp[%0d]: rvalid missing for out-of-range access", i);
      end
`endif
    end
  endtask

  task automatic test_gnt_throttle();
    logic [9:0] exp_gnt;
    logic [9:0] exp_rv;
    exp_gnt = 10'b11_0011_0011;
    exp_rv  = 10'b00_1100_1100;
    for (int i = 0; i < 10; i++) begin
      req3 = (i < 6) ? pack(1'b1, 1'b1, 4'hF, 32'(4 * i), 32'(i)) : '0;
      #1;
      checks++;
      if (gnt3 !== exp_gnt[i]) begin
        errors++; $display("[TB] FAIL throttle_gnt[%0d]: got %b want %b", i, gnt3, exp_gnt[i]);
      end
      step();
      checks++;
      if (rv3 !== exp_rv[i]) begin
        errors++; $display("[TB] FAIL throttle_rvalid[%0d]: got %b want %b", i, rv3, exp_rv[i]);
      end
      checks++;
      if (rd3 !== 32'h0) begin
        errors++; $display("[TB] FAIL throttle_rdata[%0d]: got %h want 0", i, rd3);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        exp_rv;
    logic [31:0] exp_data;
    int          src;
    for (int i = 0; i < 20; i++) begin
      if (i < 8) req4 = pack(1'b1, 1'b1, 4'hF, 32'(4 * i), 32'hC0DE_0000 + 32'(i));
      else if (i < 16) req4 = pack(1'b1, 1'b0, 4'hF, 32'(4 * (i - 8)), 32'h0);
      else req4 = '0;
      #1;
      checks++;
      if (gnt4 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_gnt[%0d]: got %b want 1", i, gnt4); end
      step();
      src      = i + 1 - 4;
      exp_rv   = (src >= 0) && (src < 16);
      exp_data = (src >= 8 && src < 16) ? 32'hC0DE_0000 + 32'(src - 8) : 32'h0;
      checks++;
      if (rv4 !== exp_rv) begin
        errors++; $display("[TB] FAIL b2b_rvalid[%0d]: got %b want %b", i, rv4, exp_rv);
      end
      checks++;
      if (rd4 !== exp_data) begin
        errors++; $display("[TB] FAIL b2b_rdata[%0d]: got %h want %h", i, rd4, exp_data);
      end
    end
  endtask

  task automatic test_reset_midflight();
    req4 = pack(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
    step();
    req4 = pack(1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
    step();
    req4  = '0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt4 !== 1'b0) begin errors++; $display("[TB] FAIL midrst_gnt: got %b want 0", gnt4); end
    checks++;
    if (rv4 !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rvalid: got %b want 0", rv4); end
    step();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rv4 !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_rvalid[%0d]: got %b want 0", i, rv4); end
      checks++;
      if (gnt4 !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_gnt[%0d]: got %b want 1", i, gnt4); end
      step();
    end
    req4 = pack(1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
    for (int j = 0; j < 5; j++) begin
      step();
      req4 = '0;
      checks++;
      if (rv4 !== (j == 3)) begin
        errors++; $display("[TB] FAIL post_rst_read_rvalid[%0d]: got %b want %b", j, rv4, (j == 3));
      end
      checks++;
      if (rd4 !== ((j == 3) ? 32'hC0DE_0002 : 32'h0)) begin
        errors++; $display("[TB] FAIL post_rst_read_rdata[%0d]: got %h", j, rd4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_out_of_range();
    test_gnt_throttle();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
